// File: rtl/mshr_cache_pkg.sv
// rtl/mshr_cache_pkg.sv - shared widths and state records for the MSHR byte cache
package mshr_cache_pkg;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 8;
  localparam int NUM_LINES    = 8;
  localparam int NUM_MSHR     = 2;
  localparam int FILL_LATENCY = 3;
  localparam int LINE_IDX_W   = $clog2(NUM_LINES);
  localparam int CNT_W        = $clog2(FILL_LATENCY + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } line_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wflag;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  cnt;
  } mshr_t;

endpackage

// File: rtl/mshr_file.sv
// rtl/mshr_file.sv - miss status holding registers: allocate, merge, count down, request fill
module mshr_file
  import mshr_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lookup_hit,
  output logic              ready,
  output logic              merge,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              fill_wflag,
  output logic [DATA_W-1:0] fill_wdata
);

  mshr_t               mshr_q [NUM_MSHR];
  logic [NUM_MSHR-1:0] match;
  logic [NUM_MSHR-1:0] alloc_oh;
  logic                alloc_req;
  logic                found;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_MSHR; i++)
      match[i] = mshr_q[i].valid && (mshr_q[i].addr == address);
  end

  always_comb begin
    ready     = 1'b0;
    for (int i = 0; i < NUM_MSHR; i++)
      if (!mshr_q[i].valid) ready = 1'b1;
    merge     = req_valid && !lookup_hit && (|match);
    alloc_req = req_valid && !lookup_hit && !(|match) && ready;
    // lowest free entry wins the allocation
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (!mshr_q[i].valid && !found) begin
        alloc_oh[i] = alloc_req;
        found       = 1'b1;
      end
    end
  end

  // a write merging on the fill cycle itself is folded into the fill data
  always_comb begin
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_wflag = 1'b0;
    fill_wdata = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (mshr_q[i].valid && (mshr_q[i].cnt == CNT_W'(1)) && !fill_valid) begin
        fill_valid = 1'b1;
        fill_addr  = mshr_q[i].addr;
        fill_wflag = mshr_q[i].wflag || (merge && match[i] && req_write);
        fill_wdata = (merge && match[i] && req_write) ? wdata : mshr_q[i].wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MSHR; i++) mshr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (mshr_q[i].valid) begin
          if (mshr_q[i].cnt == CNT_W'(1)) mshr_q[i].valid <= 1'b0;
          else                             mshr_q[i].cnt   <= mshr_q[i].cnt - CNT_W'(1);
          if (merge && match[i] && req_write) begin
            mshr_q[i].wflag <= 1'b1;
            mshr_q[i].wdata <= wdata;
          end
        end else if (alloc_oh[i]) begin
          mshr_q[i] <= '{valid: 1'b1, addr: address, wflag: req_write,
                         wdata: wdata, cnt: CNT_W'(FILL_LATENCY)};
        end
      end
    end
  end

endmodule

// File: rtl/mshr_cache.sv
// rtl/mshr_cache.sv - non-blocking fully associative byte cache with internal backing store
module mshr_cache
  import mshr_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              ready
);

  line_t                 lines_q [NUM_LINES];
  logic [DATA_W-1:0]     store_q [2**ADDR_W];
  logic [LINE_IDX_W-1:0] victim_q;
  logic                  lookup_hit;
  logic [LINE_IDX_W-1:0] hit_idx;
  logic                  fill_reuse;
  logic [LINE_IDX_W-1:0] reuse_idx;
  logic [LINE_IDX_W-1:0] fill_idx;
  logic [DATA_W-1:0]     fill_data;
  logic                  merge;
  logic                  fill_valid;
  logic [ADDR_W-1:0]     fill_addr;
  logic                  fill_wflag;
  logic [DATA_W-1:0]     fill_wdata;
  logic                  store_we;

  mshr_file u_mshr_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .address    (address),
    .wdata      (wdata),
    .lookup_hit (lookup_hit),
    .ready      (ready),
    .merge      (merge),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_wflag (fill_wflag),
    .fill_wdata (fill_wdata)
  );

  // lookup sees the tag array as it was before this edge's fill
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    fill_reuse = 1'b0;
    reuse_idx  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (lines_q[i].valid && (lines_q[i].tag == address)) begin
        lookup_hit = 1'b1;
        hit_idx    = LINE_IDX_W'(i);
      end
      if (lines_q[i].valid && (lines_q[i].tag == fill_addr)) begin
        fill_reuse = 1'b1;
        reuse_idx  = LINE_IDX_W'(i);
      end
    end
  end

  assign fill_idx  = fill_reuse ? reuse_idx : victim_q;
  assign fill_data = fill_wflag ? fill_wdata : store_q[fill_addr];
  // every accepted write goes through to the store; dropped requests change nothing
  assign store_we  = req_valid && req_write && (lookup_hit || merge || ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= '0;
      victim_q <= '0;
      hit      <= 1'b0;
      rdata    <= '0;
    end else begin
      hit <= req_valid && lookup_hit;
      if (req_valid && lookup_hit && !req_write) rdata <= lines_q[hit_idx].data;
      if (req_valid && lookup_hit && req_write)  lines_q[hit_idx].data <= wdata;
      if (fill_valid) begin
        lines_q[fill_idx] <= '{valid: 1'b1, tag: fill_addr, data: fill_data};
        if (!fill_reuse) victim_q <= victim_q + LINE_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) store_q[i] <= '0;
    end else if (store_we) begin
      store_q[address] <= wdata;
    end
  end

endmodule

// File: tb/tb_mshr_cache.sv
// tb/tb_mshr_cache.sv - directed self-checking bench for mshr_cache
module tb_mshr_cache;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] address;
  logic       req_valid;
  logic       req_write;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       hit;
  logic       ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  mshr_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .req_valid (req_valid),
    .req_write (req_write),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    address   = a;
    wdata     = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    wdata     = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    address   = 8'h00;
    req_valid = 1'b0;
    req_write = 1'b0;
    wdata     = 8'h00;
    #3 rst_n = 1'b0;
    idle(2);
    check("reset hit", 32'(hit), 0);
    check("reset rdata", 32'(rdata), 0);
    check("reset ready", 32'(ready), 1);
    @(negedge clk) rst_n = 1'b1;

    // write miss then hit
    req(1'b1, 8'h01, 8'hDE);
    check("t1 wmiss hit", 32'(hit), 0);
    check("t1 wmiss ready", 32'(ready), 1);
    idle(5);
    req(1'b0, 8'h01, 8'h00);
    check("t1 read hit", 32'(hit), 1);
    check("t1 read rdata", 32'(rdata), 32'hDE);

    // write hit
    req(1'b1, 8'h01, 8'h55);
    check("t6 whit hit", 32'(hit), 1);
    check("t6 whit rdata holds", 32'(rdata), 32'hDE);
    req(1'b0, 8'h01, 8'h00);
    check("t6 read hit", 32'(hit), 1);
    check("t6 read rdata", 32'(rdata), 32'h55);

    // MSHR full
    req(1'b0, 8'h10, 8'h00);
    check("t2 0x10 hit", 32'(hit), 0);
    check("t2 0x10 ready", 32'(ready), 1);
    req(1'b0, 8'h20, 8'h00);
    check("t2 0x20 hit", 32'(hit), 0);
    check("t2 0x20 ready", 32'(ready), 0);
    req(1'b0, 8'h30, 8'h00);
    check("t2 0x30 dropped hit", 32'(hit), 0);
    check("t2 0x30 ready", 32'(ready), 0);
    idle(5);
    check("t2 ready after fills", 32'(ready), 1);
    req(1'b0, 8'h20, 8'h00);
    check("t2 0x20 hit", 32'(hit), 1);
    check("t2 0x20 rdata", 32'(rdata), 0);
    req(1'b0, 8'h10, 8'h00);
    check("t2 0x10 hit", 32'(hit), 1);
    check("t2 0x10 rdata", 32'(rdata), 0);
    req(1'b0, 8'h30, 8'h00);
    check("t2 0x30 no fill", 32'(hit), 0);
    idle(5);

    // merge
    req(1'b1, 8'h02, 8'hBE);
    check("t3 wmiss hit", 32'(hit), 0);
    req(1'b0, 8'h02, 8'h00);
    check("t3 merge hit", 32'(hit), 0);
    check("t3 merge ready", 32'(ready), 1);
    idle(5);
    req(1'b0, 8'h02, 8'h00);
    check("t3 read hit", 32'(hit), 1);
    check("t3 read rdata", 32'(rdata), 32'hBE);

    // write arriving on the fill edge of its own address
    req(1'b1, 8'h03, 8'h11);
    idle(2);
    req(1'b1, 8'h03, 8'h22);
    check("t3b fill-edge hit", 32'(hit), 0);
    check("t3b fill-edge ready", 32'(ready), 1);
    req(1'b0, 8'h03, 8'h00);
    check("t3b read hit", 32'(hit), 1);
    check("t3b read rdata", 32'(rdata), 32'h22);

    // async reset mid-fill
    req(1'b0, 8'h50, 8'h00);
    req(1'b0, 8'h60, 8'h00);
    check("t5 ready full", 32'(ready), 0);
    req(1'b0, 8'h01, 8'h00);
    check("t5 pre hit", 32'(hit), 1);
    check("t5 pre rdata", 32'(rdata), 32'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async hit", 32'(hit), 0);
    check("t5 async rdata", 32'(rdata), 0);
    check("t5 async ready", 32'(ready), 1);
    @(negedge clk) rst_n = 1'b1;
    idle(6);
    req(1'b0, 8'h01, 8'h00);
    check("t5 0x01 flushed", 32'(hit), 0);
    req(1'b0, 8'h50, 8'h00);
    check("t5 no stale fill", 32'(hit), 0);
    idle(5);

    // replacement from a clean state
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req(1'b1, 8'(8'hA0 + k), 8'(8'h30 + k));
      check("t4 fill miss", 32'(hit), 0);
      idle(4);
    end
    for (int k = 1; k < 9; k++) begin
      req(1'b0, 8'(8'hA0 + k), 8'h00);
      check("t4 resident hit", 32'(hit), 1);
      check("t4 resident rdata", 32'(rdata), 32'(8'h30 + k));
    end
    req(1'b0, 8'hA0, 8'h00);
    check("t4 evicted miss", 32'(hit), 0);
    idle(4);
    req(1'b0, 8'hA0, 8'h00);
    check("t4 refill hit", 32'(hit), 1);
    check("t4 refill rdata", 32'(rdata), 32'h30);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
